// File: rtl/counter_pkg.sv
// Shared definitions for the one-shot 3-bit counter and its restart controller.
// Pure declarations; no logic, no latency, no flow control.
package counter_pkg;

  // Counter state encoding: counts S0..S7 once and parks in S7.
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101,
    S6 = 3'b110,
    S7 = 3'b111
  } cnt_state_e;

  localparam int PARK_LATENCY = 3;  // cycles from S4 to S7
  localparam int PROBE_WINDOW = 8;  // silent cycles that prove the counter sits in S7

  typedef enum logic [2:0] {
    ST_PROBE,
    ST_RUN,
    ST_DRAIN,
    ST_PARKED,
    ST_CLEAR
  } ctrl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and registered rising-edge pulse.
// btn edge to press pulse is 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module btn_debounce
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= 8'd0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        // The DEBOUNCE_CYCLES-th consecutive disagreeing sample flips the level.
        level <= sync2;
        cnt   <= 8'd0;
        press <= sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/counter_restart_ctrl.sv
// Restart controller: tracks when the one-shot counter parks in S7 and issues one clear per press.
// Press to pending is 2 + DEBOUNCE_CYCLES + 1 cycles; a press waits until the counter is parked.
module counter_restart_ctrl
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             btn,
  input  logic             cnt_out,
  output logic             clear,
  output logic             parked,
  output logic             pending,
  output logic [CNT_W-1:0] restarts
);

  localparam logic [2:0]       PROBE_LAST = 3'(PROBE_WINDOW - 1);
  // The cnt_out cycle itself is the first of the PARK_LATENCY cycles.
  localparam logic [1:0]       DRAIN_LAST = 2'(PARK_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  logic [2:0]  probe_cnt;
  logic [1:0]  drain_cnt;
  logic        press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .clear_n(clear_n),
    .btn    (btn),
    .press  (press)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PROBE: begin
        if (cnt_out) begin
          state_nxt = ST_DRAIN;
        end else if (probe_cnt == PROBE_LAST) begin
          state_nxt = ST_PARKED;
        end
      end
      ST_RUN: begin
        if (cnt_out) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_PARKED;
        end
      end
      // cnt_out while parked or clearing is a protocol error and is ignored.
      ST_PARKED: begin
        if (pending) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: state_nxt = ST_RUN;
      default:  state_nxt = ST_PROBE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state     <= ST_PROBE;
      probe_cnt <= 3'd0;
      drain_cnt <= 2'd0;
      clear     <= 1'b0;
      parked    <= 1'b0;
      pending   <= 1'b0;
      restarts  <= '0;
    end else begin
      state     <= state_nxt;
      probe_cnt <= (state == ST_PROBE) ? probe_cnt + 3'd1 : 3'd0;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      clear     <= (state_nxt == ST_CLEAR);
      parked    <= (state_nxt == ST_PARKED);
      // A press landing on the clearing edge re-arms pending.
      if (press) begin
        pending <= 1'b1;
      end else if (state_nxt == ST_CLEAR) begin
        pending <= 1'b0;
      end
      if (state_nxt == ST_CLEAR && restarts != '1) begin
        restarts <= restarts + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/counter_restart_ctrl.md
Name: counter_restart_ctrl

Overview:
- Upstream control stage for the 3-bit one-shot up-counter (S0..S7, parks in S7; `out` high only in S4; `clear` sampled only in S7).
- Debounces a raw restart button and tracks when the counter has parked in S7.
- Drives the counter's `clear` input for exactly one cycle per accepted press, restarting the count from S0.
- Reports parked status and a saturating restart count.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples needed before the debounced level changes (range 1..255).
- CNT_W, 8, width of the restarts counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clear_n  input  1  synchronous active-low reset.
- btn  input  1  raw asynchronous restart button, active-high.
- cnt_out  input  1  counter `out` (high while counter is in S4).
- clear  output  1  to counter `clear`; registered; one-cycle pulse.
- parked  output  1  high while the counter is known to be in S7.
- pending  output  1  a debounced press is waiting to be serviced.
- restarts  output  CNT_W  number of clear pulses issued; saturates at all-ones.

Behaviour:
- Reset (`clear_n`=0 at posedge): synchronizer flops, debounced level and debounce counter go to 0.
- Reset values: state=PROBE, probe counter=0, clear=0, parked=0, pending=0, restarts=0.
- Reset mid-operation, including during CLEAR, aborts the operation immediately; `clear` is 0 in the cycle after the reset edge.
- Input conditioning:
  - `btn` passes through a 2-flop synchronizer.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles of the synchronized value differing from it. Any agreeing sample zeroes the counter.
  - A press is a 0->1 transition of the debounced level.
  - Latency: btn edge to `pending`=1 is 2 + DEBOUNCE_CYCLES + 1 cycles.
- `pending`:
  - Set by a press.
  - Cleared in the cycle `clear` is driven high.
  - A press while `pending`=1 is discarded (no queueing beyond one).
  - A press in the same cycle `pending` is cleared sets it again.
- FSM states PROBE, RUN, DRAIN, PARKED, CLEAR:
  - PROBE (counter state unknown after power-up):
    - 3-bit probe counter counts cycles. `cnt_out`=1 -> DRAIN.
    - 8 cycles without `cnt_out` -> PARKED. Any state S0..S4 produces `out` within 5 cycles, and S5/S6 reach S7 within 2, so silence for 8 cycles proves S7.
  - RUN: counter is counting up from S0. `cnt_out`=1 -> DRAIN.
  - DRAIN: fixed 3-cycle wait (S4->S5->S6->S7), then -> PARKED. `parked` is high in the first cycle the counter is in S7, i.e. 3 cycles after the `cnt_out` cycle.
  - PARKED: `parked`=1. `pending`=1 -> CLEAR.
  - CLEAR:
    - `clear`=1 for exactly one cycle.
    - `restarts` increments, saturating at all-ones.
    - `pending` drops; `parked` drops the same cycle.
    - Next state is RUN. The counter goes S7->S0 on this edge and reaches S4 five cycles after the CLEAR cycle.
- `clear` is never high outside CLEAR, so the counter never sees `clear` outside S7.
- A `cnt_out`=1 seen in PARKED or CLEAR is a protocol error: ignored; state unchanged.
- No combinational path from any input to any output.

Decomposition:
- Shared package `counter_pkg`:
  - counter state encoding S0..S7 (3'b000..3'b111);
  - constant PARK_LATENCY=3 (cycles from S4 to S7);
  - constant PROBE_WINDOW=8;
  - typedef for the controller FSM enum.
- One natural sub-module, `btn_debounce` (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES. The top-level FSM and counters stay in counter_restart_ctrl.

Test Plan:
1. Power-up with the counter model forced to S2, `clear_n` low 2 cycles then high.
   - `cnt_out` in cycle 2; `parked`=1 three cycles later.
   - `clear` stays 0; `restarts`=0.
2. Power-up with the model at S7 and no `cnt_out`: `parked` rises exactly 8 cycles after reset release.
3. Parked, `btn` held high 10 cycles, DEBOUNCE_CYCLES=4:
   - `pending` rises 7 cycles after the btn edge;
   - `clear` one-cycle pulse the next cycle; `restarts`=1;
   - model at S4 5 cycles later; `parked` again 3 cycles after that.
4. `btn` glitches (high 3 cycles, low 1, high 3): no press, `pending` stays 0.
5. Two clean presses while RUN:
   - `pending`=1 once; exactly one `clear` after parking; `restarts`=1.
   - Saturation: preload to 255 with CNT_W=8, one more restart -> stays 255.
6. Assert `clear_n`=0 in the CLEAR cycle:
   - next cycle `clear`=0, `pending`=0, `restarts`=0, state PROBE;
   - re-probe completes correctly.
